// File: rtl/uart_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// uart_transmitter_pkg
// Shared UART definitions: the line levels, the data width and the TX state
// encoding. The UART receiver uses the same definitions, so the state values
// stay fixed whether or not the parity feature is built in.
// Contents:
//   UART_DATA_W       payload width, 8 bits
//   UART_START_LEVEL  line level of the start bit (space, 0)
//   UART_STOP_LEVEL   line level of the stop bit (mark, 1)
//   UART_IDLE_LEVEL   line level between frames (mark, 1)
//   tx_state_e        TX sequencer states, ST_IDLE..ST_STOP
// -----------------------------------------------------------------------------
package uart_transmitter_pkg;

  localparam int   UART_DATA_W      = 8;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;
  localparam logic UART_IDLE_LEVEL  = 1'b1;

  // ST_PARITY keeps its code even in builds without parity, so the
  // encoding seen by other blocks and by debug tools never shifts.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Symbol timer for the UART transmitter. clk_cnt counts 0..SYMBOL_EDGE_TIME-1
// and wraps; symbol_end pulses for one cycle on the last count of each symbol.
// While clear is high the counter is held at zero. The transmitter holds clear
// in IDLE, so the counter starts from zero on the edge that accepts a byte and
// the start bit lasts a full symbol.
// Ports:
//   clk         in   core clock
//   rst         in   asynchronous active-high reset
//   clear       in   hold the counter at zero (no symbol_end while high)
//   symbol_end  out  one-cycle pulse on the last cycle of a symbol
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int SYMBOL_EDGE_TIME = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic symbol_end
);

  localparam int CNT_W = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  logic [CNT_W-1:0] clk_cnt;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, whatever order the simulator runs blocks in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt <= '0;
    end else if (clear || symbol_end) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + CNT_W'(1);
    end
  end

  assign symbol_end = !clear && (clk_cnt == CNT_LAST);

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// UART TX for the CPU MMIO block. Takes one byte at a time over a valid/ready
// handshake and sends it on serial_out LSB first: one start bit, eight data
// bits, optional even parity, one stop bit. The line idles high. Only one
// frame is in flight and there is no FIFO.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a PARITY symbol carrying ^byte is sent
//                      between the data bits and the stop bit (8E1, 11
//                      symbols). Otherwise the frame is 8N1, 10 symbols.
//
// Parameters:
//   CLOCK_FREQ  core clock in Hz
//   BAUD_RATE   line rate in bit/s; each symbol lasts CLOCK_FREQ/BAUD_RATE
//               clocks (integer division, must be at least 2)
// Ports:
//   clk            in   core clock, all state on the rising edge
//   rst            in   asynchronous active-high reset
//   data_in[7:0]   in   byte to send, sampled only on the handshake
//   data_in_valid  in   producer has a byte
//   data_in_ready  out  high only in IDLE; byte accepted when valid && ready
//   serial_out     out  registered UART line, 1 = idle/mark
//
// Timing: serial_out falls on the same edge that accepts the byte. Every
// symbol lasts exactly SYMBOL_EDGE_TIME cycles. data_in_ready rises on the
// edge that ends the stop bit, so a byte that is already waiting is accepted
// after a single idle cycle.
// -----------------------------------------------------------------------------
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;

  tx_state_e              state_q, state_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   serial_q, serial_d;
  logic                   symbol_end;
  logic                   accept;

`ifdef UART_TX_PARITY_EN
  // The shift register is empty by the time the parity symbol is due, so
  // the parity of the byte is captured on the handshake.
  logic parity_q;
`endif

  assign data_in_ready = (state_q == ST_IDLE);
  assign accept        = data_in_valid && data_in_ready;
  assign serial_out    = serial_q;

  // The counter is held in IDLE and released on the accept edge, so it
  // reads zero during the first cycle of the start bit.
  uart_baud_tick #(
    .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
  ) u_baud_tick (
    .clk       (clk),
    .rst       (rst),
    .clear     (data_in_ready),
    .symbol_end(symbol_end)
  );

  // Next-state and next-line logic. serial_d is the level the line takes
  // for the next symbol. It is registered, so the line changes on the same
  // edge as the state.
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    serial_d  = serial_q;

    case (state_q)
      ST_IDLE: begin
        serial_d = UART_IDLE_LEVEL;
        if (accept) begin
          state_d   = ST_START;
          shift_d   = data_in;
          bit_idx_d = '0;
          serial_d  = UART_START_LEVEL;
        end
      end

      ST_START: begin
        if (symbol_end) begin
          state_d  = ST_DATA;
          serial_d = shift_q[0];
        end
      end

      ST_DATA: begin
        if (symbol_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;  // wraps 7 -> 0 on the last bit
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d  = ST_PARITY;
            serial_d = parity_q;
`else
            state_d  = ST_STOP;
            serial_d = UART_STOP_LEVEL;
`endif
          end else begin
            // The next bit is shift_q[1] now, and it is shift_q[0] once
            // the shift has taken effect.
            serial_d = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (symbol_end) begin
          state_d  = ST_STOP;
          serial_d = UART_STOP_LEVEL;
        end
      end
`endif

      ST_STOP: begin
        if (symbol_end) begin
          state_d  = ST_IDLE;
          serial_d = UART_IDLE_LEVEL;
        end
      end

      default: begin
        // Unused codes, and ST_PARITY in a build without parity, go back
        // to a quiet line.
        state_d  = ST_IDLE;
        serial_d = UART_IDLE_LEVEL;
      end
    endcase
  end

  // The asynchronous reset forces the line to mark immediately, which
  // aborts a frame in flight without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      serial_q  <= UART_IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^data_in;
    end
  end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Self-checking bench for uart_transmitter at 50 MHz / 1 Mbaud (50 clk/bit).
// serial_out is logged once per cycle on the falling clock edge. A software
// UART receiver then decodes the log. It finds each falling edge, samples the
// centre of every symbol and checks the stop bit and the parity bit. The
// decoded frames are compared against a table of hand-written frames and
// against an arithmetic frame model for random bytes.
// Define UART_TX_PARITY_EN for both the bench and the RTL to check 8E1 framing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 1_000_000;
  localparam int SYM        = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int NSYM = 11;
`else
  localparam int NSYM = 10;
`endif
  localparam int FRAME = SYM * NSYM;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;

  uart_transmitter #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic       line_log[$];  // serial_out, one sample per cycle
  int         low_cnt;      // number of logged cycles with data_in_ready low
  logic [7:0] tx_q[$];      // bytes waiting to be offered
  logic [7:0] sent_q[$];    // bytes that were offered on an accepting edge
  int         acc_cyc[$];   // cycle number of each accepting edge
  logic [7:0] dec_q[$];     // bytes decoded from line_log
  int         dec_err;      // framing or parity errors seen by the decoder

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;  // symbol k of the frame is bit k
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected frame, built from the framing rules: bit 0 is the start bit,
  // the byte follows LSB first, then the optional parity bit and the stop bit.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int v;
    v = 2 * int'(b);
`ifdef UART_TX_PARITY_EN
    v += ($countones(b) % 2) * 512;
    v += 1024;
`else
    v += 512;
`endif
    return 11'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic tick();
    step();
    line_log.push_back(serial_out);
    if (!data_in_ready) low_cnt++;
  endtask

  task automatic clear_log();
    line_log.delete();
    line_log.push_back(serial_out);
    low_cnt = 0;
    acc_cyc.delete();
    sent_q.delete();
  endtask

  // Offer the bytes in tx_q with valid held high until the queue is empty
  // and the transmitter is idle again.
  task automatic stream(input string name, input int max_cycles);
    int c;
    c = 0;
    while ((tx_q.size() > 0 || !data_in_ready) && c < max_cycles) begin
      if (tx_q.size() > 0) begin
        data_in_valid = 1'b1;
        data_in       = tx_q[0];
        if (data_in_ready) begin
          acc_cyc.push_back(cyc);
          sent_q.push_back(tx_q.pop_front());
        end
      end else begin
        data_in_valid = 1'b0;
      end
      tick();
      c++;
    end
    data_in_valid = 1'b0;
    if (c >= max_cycles) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: still busy after %0d cycles", name, c);
      tx_q.delete();
    end
  endtask

  // Software UART receiver working on line_log.
  task automatic decode_log();
    int i;
    logic [7:0] b;
    dec_q.delete();
    dec_err = 0;
    i = 1;
    while (i + SYM / 2 + SYM * (NSYM - 1) < line_log.size()) begin
      if (line_log[i-1] === 1'b1 && line_log[i] === 1'b0) begin
        if (line_log[i + SYM / 2] !== 1'b0) dec_err++;
        for (int k = 0; k < 8; k++) b[k] = line_log[i + SYM / 2 + SYM * (k + 1)];
`ifdef UART_TX_PARITY_EN
        if (line_log[i + SYM / 2 + SYM * 9] !== ^b) dec_err++;
`endif
        if (line_log[i + SYM / 2 + SYM * (NSYM - 1)] !== 1'b1) dec_err++;
        dec_q.push_back(b);
        i = i + SYM / 2 + SYM * (NSYM - 1);
      end else begin
        i++;
      end
    end
  endtask

  // Raw symbol-centre samples of the first frame in line_log.
  task automatic get_frame(output logic [10:0] f, output logic found);
    f = '0;
    found = 1'b0;
    for (int i = 1; i + SYM / 2 + SYM * (NSYM - 1) < line_log.size(); i++) begin
      if (line_log[i-1] === 1'b1 && line_log[i] === 1'b0) begin
        for (int k = 0; k < NSYM; k++) f[k] = line_log[i + SYM / 2 + SYM * k];
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    logic        found;
    logic [7:0]  b;
    int          errs;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h0d, 11'b11000011010};
    vecs[1] = '{8'h31, 11'b11001100010};
    vecs[2] = '{8'h78, 11'b10011110000};
    vecs[3] = '{8'hff, 11'b10111111110};
    vecs[4] = '{8'h00, 11'b10000000000};
    vecs[5] = '{8'h80, 11'b11100000000};
`else
    vecs[0] = '{8'h0d, 11'b01000011010};
    vecs[1] = '{8'h31, 11'b01001100010};
    vecs[2] = '{8'h78, 11'b01011110000};
    vecs[3] = '{8'hff, 11'b01111111110};
    vecs[4] = '{8'h00, 11'b01000000000};
    vecs[5] = '{8'h80, 11'b01100000000};
`endif

    rst           = 1'b1;
    data_in_valid = 1'b0;
    data_in       = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_serial_out", 32'(serial_out), 32'd1);
    check("reset_ready", 32'(data_in_ready), 32'd1);
    rst = 1'b0;

    // Idle line after reset, with no valid.
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (serial_out !== 1'b1 || data_in_ready !== 1'b1) errs++;
    end
    check("idle_1000_cycles", 32'(errs), 32'd0);

    // Table of single frames.
    foreach (vecs[v]) begin
      clear_log();
      tx_q.push_back(vecs[v].data);
      stream("table", 2 * FRAME);
      get_frame(f, found);
      check($sformatf("table_%02h_found", vecs[v].data), 32'(found), 32'd1);
      check($sformatf("table_%02h_frame", vecs[v].data), 32'(f), 32'(vecs[v].frame));
      check($sformatf("table_%02h_latency", vecs[v].data), 32'(line_log[1]), 32'd0);
      check($sformatf("table_%02h_ready_low", vecs[v].data), 32'(low_cnt), 32'(FRAME));
    end

    // Back-to-back bytes with valid held high.
    clear_log();
    tx_q = '{8'h78, 8'h79, 8'h7a, 8'h0d};
    stream("b2b", 4 * FRAME + 100);
    repeat (5) tick();
    decode_log();
    check("b2b_count", 32'(dec_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < dec_q.size() && i < sent_q.size(); i++)
      check($sformatf("b2b_byte%0d", i), 32'(dec_q[i]), 32'(sent_q[i]));
    check("b2b_frame_errors", 32'(dec_err), 32'd0);
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("b2b_gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(FRAME + 1));
    check("b2b_ready_low", 32'(low_cnt), 32'(4 * FRAME));

    // data_in changes mid-frame; the second byte waits for ready.
    clear_log();
    data_in       = 8'h31;
    data_in_valid = 1'b1;
    tick();
    errs = 0;
    while (!data_in_ready && errs < 2 * FRAME) begin
      if (low_cnt == 200) data_in = 8'hff;
      tick();
      errs++;
    end
    check("midchange_ready_low", 32'(low_cnt), 32'(FRAME));
    tick();
    check("midchange_second_start", 32'(serial_out), 32'd0);
    data_in_valid = 1'b0;
    errs = 0;
    while (!data_in_ready && errs < 2 * FRAME) begin
      tick();
      errs++;
    end
    repeat (5) tick();
    decode_log();
    check("midchange_count", 32'(dec_q.size()), 32'd2);
    if (dec_q.size() == 2) begin
      check("midchange_first", 32'(dec_q[0]), 32'h31);
      check("midchange_second", 32'(dec_q[1]), 32'hff);
    end

    // Reset 230 cycles into a frame.
    clear_log();
    data_in       = 8'h55;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    repeat (230) tick();
    check("abort_line_before_reset", 32'(serial_out), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_line_async", 32'(serial_out), 32'd1);
    check("abort_ready_async", 32'(data_in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    // Reset and valid together: reset wins and the byte is dropped.
    @(negedge clk);
    rst           = 1'b1;
    data_in_valid = 1'b1;
    data_in       = 8'ha5;
    step();
    rst           = 1'b0;
    data_in_valid = 1'b0;
    check("rst_valid_ready", 32'(data_in_ready), 32'd1);
    clear_log();
    repeat (FRAME + 100) tick();
    errs = 0;
    foreach (line_log[i]) if (line_log[i] !== 1'b1) errs++;
    check("abort_no_resume", 32'(errs), 32'd0);
    tx_q.push_back(8'h3e);
    stream("after_abort", 2 * FRAME);
    repeat (5) tick();
    decode_log();
    check("after_abort_count", 32'(dec_q.size()), 32'd1);
    if (dec_q.size() == 1) check("after_abort_byte", 32'(dec_q[0]), 32'h3e);
    check("after_abort_frame_errors", 32'(dec_err), 32'd0);

    // Random single bytes after random idle gaps, checked against the frame model.
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      clear_log();
      repeat ($urandom_range(0, 20)) tick();
      tx_q.push_back(b);
      stream("rand", 2 * FRAME);
      get_frame(f, found);
      check($sformatf("rand_%02h_frame", b), 32'(f), 32'(ref_frame(b)));
      check($sformatf("rand_%02h_ready_low", b), 32'(low_cnt), 32'(FRAME));
    end

    // Random back-to-back burst, decoded by the software receiver.
    clear_log();
    for (int n = 0; n < 5; n++) tx_q.push_back(8'($urandom));
    stream("rand_burst", 5 * FRAME + 100);
    repeat (5) tick();
    decode_log();
    check("rand_burst_count", 32'(dec_q.size()), 32'd5);
    for (int i = 0; i < dec_q.size() && i < sent_q.size(); i++)
      check($sformatf("rand_burst_byte%0d", i), 32'(dec_q[i]), 32'(sent_q[i]));
    check("rand_burst_frame_errors", 32'(dec_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
